burst_slave_rw: RTL

BURST_SLAVE_RW -- requirements
Module: burst_slave_rw

---
 rtl/burst_slave_rw.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/burst_slave_rw.sv
// burst_slave_rw: burst-capable memory slave with read and write bursts on a simple
// waitrequest/readdatavalid interface, plus a sticky protocol-error flag.
// Optional feature: define BURST_SLAVE_THROTTLE_EN to insert one stall cycle after
// every THROTTLE_PERIOD accepted write beats.
module burst_slave_rw #(
  parameter int unsigned DW              = 32,
  parameter int unsigned AW              = 32,
  parameter int unsigned DEPTH_LOG2      = 8,
  parameter int unsigned BURSTCOUNTWIDTH = 5,
  parameter int unsigned BYTEENABLEWIDTH = DW / 8,
  parameter int unsigned THROTTLE_PERIOD = 4
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic [AW-1:0]              avms_address,
  input  logic [BURSTCOUNTWIDTH-1:0] avms_burstcount,
  input  logic [BYTEENABLEWIDTH-1:0] avms_byteenable,
  input  logic                       avms_write,
  input  logic                       avms_read,
  input  logic [DW-1:0]              avms_writedata,
  output logic                       avms_waitrequest,
  output logic [DW-1:0]              avms_readdata,
  output logic                       avms_readdatavalid,
  output logic                       err_o
);

  localparam int unsigned BE_LOG2   = $clog2(BYTEENABLEWIDTH);
  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned MAX_BURST = 1 << (BURSTCOUNTWIDTH - 1);
  localparam int unsigned BCW       = BURSTCOUNTWIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [BCW-1:0]        rem_q, rem_d;
  logic                  err_d, rdv_d, wait_d;

  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] first_idx_c;
  logic [BCW-1:0]        bc_c;
  logic                  bc_over_c;
  logic                  mem_we_c, rd_en_c, wr_acc_c, stall_c;
  logic [DEPTH_LOG2-1:0] mem_wa_c, rd_a_c;

  // Address bits above the word index and below the byte lane are don't-care.
  logic unused_c;
  assign unused_c = ^{avms_address, THROTTLE_PERIOD};

  // Starting word index and effective burst length (0 -> 1, oversize -> clamped).
  always_comb begin
    first_idx_c = DEPTH_LOG2'(avms_address >> BE_LOG2);
    bc_over_c   = (avms_burstcount > BCW'(MAX_BURST));
    if (avms_burstcount == '0) begin
      bc_c = BCW'(1);
    end else if (bc_over_c) begin
      bc_c = BCW'(MAX_BURST);
    end else begin
      bc_c = avms_burstcount;
    end
  end

`ifdef BURST_SLAVE_THROTTLE_EN
  localparam int unsigned TW = (THROTTLE_PERIOD > 1) ? $clog2(THROTTLE_PERIOD) : 1;
  logic [TW-1:0] thr_q, thr_d;

  // Accepted-write-beat counter; persists across bursts, cleared only by reset.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      thr_q <= '0;
    end else begin
      thr_q <= thr_d;
    end
  end
`endif

  // Next-state, beat bookkeeping and memory strobes.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    err_d    = err_q_w();
    rdv_d    = 1'b0;
    mem_we_c = 1'b0;
    mem_wa_c = idx_q;
    rd_en_c  = 1'b0;
    rd_a_c   = idx_q;
    wr_acc_c = 1'b0;
    stall_c  = 1'b0;
`ifdef BURST_SLAVE_THROTTLE_EN
    thr_d    = thr_q;
`endif
    case (state_q)
      IDLE: begin
        if (avms_write && !avms_waitrequest) begin
          wr_acc_c = 1'b1;
          mem_we_c = 1'b1;
          mem_wa_c = first_idx_c;
          idx_d    = first_idx_c + DEPTH_LOG2'(1);
          rem_d    = bc_c - BCW'(1);
          err_d    = err_o | bc_over_c;
          if (bc_c > BCW'(1)) begin
            state_d = WRITE;
          end
        end else if (avms_read && !avms_waitrequest) begin
          rd_en_c = 1'b1;
          rd_a_c  = first_idx_c;
          rdv_d   = 1'b1;
          idx_d   = first_idx_c + DEPTH_LOG2'(1);
          rem_d   = bc_c - BCW'(1);
          err_d   = err_o | bc_over_c;
          state_d = READ;
        end
      end
      WRITE: begin
        if (avms_read) begin
          err_d = 1'b1;
        end
        if (avms_write && !avms_waitrequest) begin
          wr_acc_c = 1'b1;
          mem_we_c = 1'b1;
          idx_d    = idx_q + DEPTH_LOG2'(1);
          rem_d    = rem_q - BCW'(1);
          if (rem_q == BCW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      READ: begin
        if (rem_q != '0) begin
          rd_en_c = 1'b1;
          rdv_d   = 1'b1;
          idx_d   = idx_q + DEPTH_LOG2'(1);
          rem_d   = rem_q - BCW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef BURST_SLAVE_THROTTLE_EN
    if (wr_acc_c) begin
      if (thr_q == TW'(THROTTLE_PERIOD - 1)) begin
        thr_d   = '0;
        stall_c = 1'b1;
      end else begin
        thr_d = thr_q + TW'(1);
      end
    end
`endif
    wait_d = (state_d == READ) || stall_c;
  end

  function automatic logic err_q_w();
    return err_o;
  endfunction

  // Control registers; waitrequest is held high throughout reset.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q            <= IDLE;
      idx_q              <= '0;
      rem_q              <= '0;
      err_o              <= 1'b0;
      avms_readdatavalid <= 1'b0;
      avms_waitrequest   <= 1'b1;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      rem_q              <= rem_d;
      err_o              <= err_d;
      avms_readdatavalid <= rdv_d;
      avms_waitrequest   <= wait_d;
    end
  end

  // Storage and read port; contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we_c) begin
      for (int i = 0; i < int'(BYTEENABLEWIDTH); i++) begin
        if (avms_byteenable[i]) begin
          mem[mem_wa_c][8*i +: 8] <= avms_writedata[8*i +: 8];
        end
      end
    end
    if (rd_en_c) begin
      avms_readdata <= mem[rd_a_c];
    end
  end

endmodule
